lc3_mem_responder: RTL

LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

---
 rtl/lc3_mem_pkg.sv | 39 +++
 rtl/lc3_mem_array.sv | 25 ++
 rtl/lc3_mem_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory responder.
// Holds the memory-mapped I/O addresses, the handshake FSM state enum and
// an address decoder used by the responder when it accepts a request.
package lc3_mem_pkg;

  localparam logic [15:0] ADDR_KBSR    = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR    = 16'hFE02;
  localparam logic [15:0] ADDR_DSR     = 16'hFE04;
  localparam logic [15:0] ADDR_DDR     = 16'hFE06;
  // First address of the reserved hole; everything from here up reads zero.
  localparam logic [15:0] ADDR_IO_HOLE = 16'hFE08;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } mem_state_t;

  typedef enum logic [2:0] {
    TGT_RAM,
    TGT_KBSR,
    TGT_KBDR,
    TGT_DSR,
    TGT_DDR,
    TGT_NONE
  } mem_tgt_t;

  // Only the four exact register addresses and the top hole are I/O;
  // odd addresses between the registers (xFE01 etc.) fall through to RAM.
  function automatic mem_tgt_t decode_addr(input logic [15:0] a);
    if (a >= ADDR_IO_HOLE)   return TGT_NONE;
    else if (a == ADDR_KBSR) return TGT_KBSR;
    else if (a == ADDR_KBDR) return TGT_KBDR;
    else if (a == ADDR_DSR)  return TGT_DSR;
    else if (a == ADDR_DDR)  return TGT_DDR;
    else                     return TGT_RAM;
  endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// Synchronous single-port RAM, 2**DEPTH_BITS x 16.
// Ports: clk, en (port enable), we (write when en), addr, wdata,
//        rdata (registered read data, holds its value while en=0).
// Contents are deliberately not reset.
module lc3_mem_array #(
  parameter int DEPTH_BITS = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  logic [15:0] mem [0:(1<<DEPTH_BITS)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: RAM plus keyboard/display memory-mapped I/O behind
// a memReq/memReady handshake with WAIT_STATES idle cycles per access.
// Ports: clk, reset (async, active low); CPU side memReq, address,
//        dataToMemory, writeEnable -> dataFromMemory, memReady;
//        keyboard kbdValid/kbdData -> kbdReady; display dispValid/dispData
//        <- dispReady.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int DEPTH_BITS  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memReq,
  input  logic [15:0] address,
  input  logic [15:0] dataToMemory,
  input  logic        writeEnable,
  output logic [15:0] dataFromMemory,
  output logic        memReady,
  input  logic        kbdValid,
  input  logic [7:0]  kbdData,
  output logic        kbdReady,
  output logic        dispValid,
  output logic [7:0]  dispData,
  input  logic        dispReady
);

  localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  mem_state_t  state, nstate;
  logic [3:0]  wait_cnt;
  logic [15:0] lat_addr, lat_wdata;
  logic        lat_we;
  mem_tgt_t    lat_tgt;
  logic        kbd_full;
  logic [7:0]  kbd_char;
  logic [15:0] ram_rdata;
  logic        accept, ram_en, ram_we;
  logic        kbdr_rd, ddr_wr;

  assign accept = (state == ST_IDLE) && memReq;

  // The RAM read is launched on the accept edge so that data is already
  // sitting in the RAM output register by RESP, even with zero wait states.
  // The write uses the same port in RESP, when no accept can happen.
  assign ram_we = (state == ST_RESP) && lat_we && (lat_tgt == TGT_RAM);
  assign ram_en = accept || ram_we;

  lc3_mem_array #(.DEPTH_BITS(DEPTH_BITS)) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (accept ? address[DEPTH_BITS-1:0] : lat_addr[DEPTH_BITS-1:0]),
    .wdata (lat_wdata),
    .rdata (ram_rdata)
  );

  // State register, wait counter and request capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      lat_addr  <= 16'h0;
      lat_wdata <= 16'h0;
      lat_we    <= 1'b0;
      lat_tgt   <= TGT_NONE;
    end else begin
      state <= nstate;
      if (state == ST_WAIT && wait_cnt != WS_LAST) wait_cnt <= wait_cnt + 4'd1;
      else                                         wait_cnt <= 4'd0;
      if (accept) begin
        lat_addr  <= address;
        lat_wdata <= dataToMemory;
        lat_we    <= writeEnable;
        lat_tgt   <= decode_addr(address);
      end
    end
  end

  // Next state; memReq is only looked at in IDLE, so dropping it later
  // does not abort the access.
  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (memReq) nstate = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt == WS_LAST) nstate = ST_RESP;
      ST_RESP: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  // Outputs and RESP-cycle side effects
  always_comb begin
    memReady       = (state == ST_RESP);
    dataFromMemory = 16'h0;
    kbdr_rd        = 1'b0;
    ddr_wr         = 1'b0;
    if (state == ST_RESP) begin
      if (lat_we) begin
        ddr_wr = (lat_tgt == TGT_DDR);
      end else begin
        case (lat_tgt)
          TGT_RAM:  dataFromMemory = ram_rdata;
          TGT_KBSR: dataFromMemory = {kbd_full, 15'b0};
          TGT_KBDR: begin
            dataFromMemory = {8'h00, kbd_char};
            kbdr_rd        = 1'b1;
          end
          TGT_DSR:  dataFromMemory = {!dispValid, 15'b0};
          default:  dataFromMemory = 16'h0;
        endcase
      end
    end
  end

  assign kbdReady = !kbd_full;

  // Keyboard holding register; a KBDR read clear beats a same-cycle offer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kbd_full <= 1'b0;
      kbd_char <= 8'h0;
    end else if (kbdr_rd) begin
      kbd_full <= 1'b0;
    end else if (kbdValid && kbdReady) begin
      kbd_full <= 1'b1;
      kbd_char <= kbdData;
    end
  end

  // Display holding register; writes while a character is pending are lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dispValid <= 1'b0;
      dispData  <= 8'h0;
    end else if (ddr_wr && !dispValid) begin
      dispValid <= 1'b1;
      dispData  <= lat_wdata[7:0];
    end else if (dispValid && dispReady) begin
      dispValid <= 1'b0;
    end
  end

endmodule
